// File: rtl/register_file_sb_pkg.sv
// Shared widths and types for the integer register file and its scoreboard.
package register_file_sb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    // Writeback request payload for the default core configuration.
    typedef struct packed {
        logic      en;
        reg_addr_t addr;
        xlen_t     data;
    } wr_req_t;

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/writeback-facing bus of the register file: write, reads, alloc, flush.
interface register_file_sb_if
    import register_file_sb_pkg::*;
#(
    parameter int unsigned WIDTH      = XLEN,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned NUM_RD     = 2
);
    logic                         wr_en;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [WIDTH-1:0]             wr_data;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*WIDTH-1:0]      rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic                         alloc_en;
    logic [ADDR_WIDTH-1:0]        alloc_addr;
    logic                         flush;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, alloc_en, alloc_addr, flush,
        input  rd_data, rd_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, alloc_en, alloc_addr, flush,
        output rd_data, rd_busy
    );

endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set on alloc, cleared on writeback.
module regfile_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int unsigned DEPTH      = NUM_REGS,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_ok,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic                         alloc_en,
    input  logic [ADDR_WIDTH-1:0]        alloc_addr,
    input  logic                         flush,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    input  logic [NUM_RD-1:0]            bypass_hit,
    output logic [NUM_RD-1:0]            rd_busy
);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < (ADDR_WIDTH+1)'(DEPTH));
    endfunction

    logic [DEPTH-1:0]      pending;
    logic [DEPTH-1:0]      pending_nxt;
    logic                  alloc_ok;
    logic [ADDR_WIDTH-1:0] ra;

    assign alloc_ok = alloc_en && (alloc_addr != '0) && in_range(alloc_addr);

    // Flush beats alloc; alloc (younger producer) beats a same-register writeback clear.
    always_comb begin
        pending_nxt = pending;
        if (flush) begin
            pending_nxt = '0;
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (alloc_ok && (alloc_addr == ADDR_WIDTH'(i))) begin
                    pending_nxt[i] = 1'b1;
                end else if (wr_ok && (wr_addr == ADDR_WIDTH'(i))) begin
                    pending_nxt[i] = 1'b0;
                end
            end
        end
    end

    // Pending vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Per-port busy; a bypass hit supplies the data this cycle so it is not a stall.
    always_comb begin
        rd_busy = '0;
        ra      = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            ra = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            if ((ra != '0) && in_range(ra)) begin
                rd_busy[p] = pending[ra] && !bypass_hit[p];
            end
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// Multi-read-port integer register file with write bypass and pending scoreboard.
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int unsigned WIDTH      = XLEN,
    parameter int unsigned DEPTH      = NUM_REGS,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned BYPASS     = 1
) (
    input logic               clk,
    input logic               rst_n,
    register_file_sb_if.slave bus
);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < (ADDR_WIDTH+1)'(DEPTH));
    endfunction

    logic [WIDTH-1:0]        regs [DEPTH];
    logic                    wr_ok;
    logic [NUM_RD-1:0]       hit;
    logic [NUM_RD-1:0]       busy;
    logic [NUM_RD*WIDTH-1:0] rd_data_all;

    assign wr_ok = bus.wr_en && (bus.wr_addr != '0) && in_range(bus.wr_addr);

    // Storage; register 0 is never written so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (bus.wr_addr == ADDR_WIDTH'(i)) begin
                    regs[i] <= bus.wr_data;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [WIDTH-1:0]      base;

        assign ra = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Stored value; zero register and unimplemented addresses read 0.
        always_comb begin
            base = '0;
            if ((ra != '0) && in_range(ra)) begin
                base = regs[ra];
            end
        end

        assign hit[p] = (BYPASS != 0) && rst_n && wr_ok && (bus.wr_addr == ra);
        assign rd_data_all[p*WIDTH +: WIDTH] = !rst_n ? '0 : (hit[p] ? bus.wr_data : base);
    end

    regfile_scoreboard #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_ok      (wr_ok),
        .wr_addr    (bus.wr_addr),
        .alloc_en   (bus.alloc_en),
        .alloc_addr (bus.alloc_addr),
        .flush      (bus.flush),
        .rd_addr    (bus.rd_addr),
        .bypass_hit (hit),
        .rd_busy    (busy)
    );

    assign bus.rd_data = rd_data_all;
    assign bus.rd_busy = busy;

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: three configurations driven by one directed stimulus stream.
module tb_register_file_sb;
    import register_file_sb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        flush;
    logic [4:0]  ra [4];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // a: 32 regs, 2 ports, bypass; b: same without bypass; c: 24 regs, 4 ports, bypass
    register_file_sb_if #(.WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) bus_a ();
    register_file_sb_if #(.WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) bus_b ();
    register_file_sb_if #(.WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(4)) bus_c ();

    assign bus_a.wr_en      = wr_en;
    assign bus_a.wr_addr    = wr_addr;
    assign bus_a.wr_data    = wr_data;
    assign bus_a.alloc_en   = alloc_en;
    assign bus_a.alloc_addr = alloc_addr;
    assign bus_a.flush      = flush;
    assign bus_a.rd_addr    = {ra[1], ra[0]};

    assign bus_b.wr_en      = wr_en;
    assign bus_b.wr_addr    = wr_addr;
    assign bus_b.wr_data    = wr_data;
    assign bus_b.alloc_en   = alloc_en;
    assign bus_b.alloc_addr = alloc_addr;
    assign bus_b.flush      = flush;
    assign bus_b.rd_addr    = {ra[1], ra[0]};

    assign bus_c.wr_en      = wr_en;
    assign bus_c.wr_addr    = wr_addr;
    assign bus_c.wr_data    = wr_data;
    assign bus_c.alloc_en   = alloc_en;
    assign bus_c.alloc_addr = alloc_addr;
    assign bus_c.flush      = flush;
    assign bus_c.rd_addr    = {ra[3], ra[2], ra[1], ra[0]};

    register_file_sb #(.WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    register_file_sb #(.WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    register_file_sb #(.WIDTH(32), .DEPTH(24), .ADDR_WIDTH(5), .NUM_RD(4), .BYPASS(1))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    // Reference state: index 0 models a 32-entry file, index 1 a 24-entry file.
    logic [31:0] mdl_mem  [2][32];
    logic        mdl_pend [2][32];

    function automatic int depth_of(input int k);
        return (k == 0) ? 32 : 24;
    endfunction

    function automatic bit valid_addr(input int k, input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < depth_of(k));
    endfunction

    // Architectural update each edge: data on write, pending by flush > alloc > write.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 32; i++) begin
                    mdl_mem[k][i]  <= 32'd0;
                    mdl_pend[k][i] <= 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wr_en && valid_addr(k, wr_addr)) begin
                    mdl_mem[k][wr_addr] <= wr_data;
                end
                for (int i = 0; i < 32; i++) begin
                    if (flush) begin
                        mdl_pend[k][i] <= 1'b0;
                    end else if (alloc_en && valid_addr(k, alloc_addr) && (int'(alloc_addr) == i)) begin
                        mdl_pend[k][i] <= 1'b1;
                    end else if (wr_en && valid_addr(k, wr_addr) && (int'(wr_addr) == i)) begin
                        mdl_pend[k][i] <= 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic [31:0] exp_data(input int k, input bit byp, input logic [4:0] a);
        if (!rst_n || !valid_addr(k, a)) return 32'd0;
        if (byp && wr_en && (wr_addr == a)) return wr_data;
        return mdl_mem[k][a];
    endfunction

    function automatic logic exp_busy(input int k, input bit byp, input logic [4:0] a);
        if (!rst_n || !valid_addr(k, a)) return 1'b0;
        if (byp && wr_en && (wr_addr == a)) return 1'b0;
        return mdl_pend[k][a];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Every falling edge: all ports of all configurations against the model.
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            check($sformatf("a_rd%0d", p), bus_a.rd_data[p*32 +: 32], exp_data(0, 1'b1, ra[p]));
            check($sformatf("a_busy%0d", p), {31'd0, bus_a.rd_busy[p]}, {31'd0, exp_busy(0, 1'b1, ra[p])});
            check($sformatf("b_rd%0d", p), bus_b.rd_data[p*32 +: 32], exp_data(0, 1'b0, ra[p]));
            check($sformatf("b_busy%0d", p), {31'd0, bus_b.rd_busy[p]}, {31'd0, exp_busy(0, 1'b0, ra[p])});
        end
        for (int p = 0; p < 4; p++) begin
            check($sformatf("c_rd%0d", p), bus_c.rd_data[p*32 +: 32], exp_data(1, 1'b1, ra[p]));
            check($sformatf("c_busy%0d", p), {31'd0, bus_c.rd_busy[p]}, {31'd0, exp_busy(1, 1'b1, ra[p])});
        end
    end

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic step();
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        alloc_en = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
        for (int i = 0; i < 4; i++) ra[i] = '0;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset mid-stream, including an in-flight write
        step(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; ra[0] = 5'd5;
        #1 check("lit_byp_wr5", bus_a.rd_data[31:0], 32'hDEADBEEF);
        step();
        #1 check("lit_rd5_a", bus_a.rd_data[31:0], 32'hDEADBEEF);
        check("lit_rd5_b", bus_b.rd_data[31:0], 32'hDEADBEEF);
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66666666; ra[1] = 5'd6;
        #1 rst_n = 1'b0;
        #1 check("lit_rst_rd5", bus_a.rd_data[31:0], 32'd0);
        check("lit_rst_byp6", bus_a.rd_data[63:32], 32'd0);
        check("lit_rst_busy", {30'd0, bus_a.rd_busy}, 32'd0);
        step();
        step(); rst_n = 1'b1;
        #1 check("lit_post_rst5", bus_a.rd_data[31:0], 32'd0);
        check("lit_post_rst6", bus_a.rd_data[63:32], 32'd0);

        // Zero register ignores writes and allocs
        step(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        alloc_en = 1'b1; alloc_addr = 5'd0; ra[0] = 5'd0; ra[1] = 5'd0;
        #1 check("lit_x0_same", bus_a.rd_data[31:0], 32'd0);
        step();
        #1 check("lit_x0_rd", bus_a.rd_data[31:0], 32'd0);
        check("lit_x0_busy", {31'd0, bus_a.rd_busy[0]}, 32'd0);
        step();

        // Bypass on both ports vs. no-bypass configuration
        step(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; ra[0] = 5'd7; ra[1] = 5'd7;
        #1 check("lit_byp_p0", bus_a.rd_data[31:0], 32'h12345678);
        check("lit_byp_p1", bus_a.rd_data[63:32], 32'h12345678);
        check("lit_nobyp_p0", bus_b.rd_data[31:0], 32'd0);
        check("lit_nobyp_p1", bus_b.rd_data[63:32], 32'd0);
        step();
        #1 check("lit_nobyp_next", bus_b.rd_data[63:32], 32'h12345678);

        // Scoreboard set and clear
        step(); alloc_en = 1'b1; alloc_addr = 5'd3; ra[0] = 5'd3; ra[1] = 5'd3;
        #1 check("lit_alloc_same", {31'd0, bus_a.rd_busy[0]}, 32'd0);
        step();
        #1 check("lit_busy3_a", {31'd0, bus_a.rd_busy[0]}, 32'd1);
        check("lit_busy3_b", {31'd0, bus_b.rd_busy[0]}, 32'd1);
        step(); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h000000A5;
        #1 check("lit_wb3_busy_a", {31'd0, bus_a.rd_busy[0]}, 32'd0);
        check("lit_wb3_rd_a", bus_a.rd_data[31:0], 32'h000000A5);
        check("lit_wb3_busy_b", {31'd0, bus_b.rd_busy[0]}, 32'd1);
        check("lit_wb3_rd_b", bus_b.rd_data[31:0], 32'd0);
        step();
        #1 check("lit_after3_a", {31'd0, bus_a.rd_busy[0]}, 32'd0);
        check("lit_after3_b", {31'd0, bus_b.rd_busy[0]}, 32'd0);
        check("lit_after3_rd_b", bus_b.rd_data[31:0], 32'h000000A5);

        // Alloc and write to the same register: alloc wins
        step(); alloc_en = 1'b1; alloc_addr = 5'd9; ra[0] = 5'd9;
        step(); alloc_en = 1'b1; alloc_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        #1 check("lit_r9_byp", bus_a.rd_data[31:0], 32'h99);
        check("lit_r9_byp_busy", {31'd0, bus_a.rd_busy[0]}, 32'd0);
        step();
        #1 check("lit_r9_busy", {31'd0, bus_a.rd_busy[0]}, 32'd1);
        check("lit_r9_rd", bus_a.rd_data[31:0], 32'h99);
        step(); alloc_en = 1'b1; alloc_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
        ra[0] = 5'd4; ra[1] = 5'd6;
        step();
        #1 check("lit_r4_busy", {31'd0, bus_a.rd_busy[0]}, 32'd1);
        check("lit_r6_busy", {31'd0, bus_a.rd_busy[1]}, 32'd0);
        check("lit_r6_rd", bus_a.rd_data[63:32], 32'h66);

        // Flush discards pending bits and the same-cycle alloc
        ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd31; ra[3] = 5'd10;
        step(); alloc_en = 1'b1; alloc_addr = 5'd1;
        step(); alloc_en = 1'b1; alloc_addr = 5'd2;
        step(); alloc_en = 1'b1; alloc_addr = 5'd31;
        step(); flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd10;
        #1 check("lit_pre_fl_c0", {31'd0, bus_c.rd_busy[0]}, 32'd1);
        check("lit_pre_fl_c1", {31'd0, bus_c.rd_busy[1]}, 32'd1);
        check("lit_pre_fl_c2_oor", {31'd0, bus_c.rd_busy[2]}, 32'd0);
        step();
        #1 check("lit_fl_c", {28'd0, bus_c.rd_busy}, 32'd0);
        check("lit_fl_a", {30'd0, bus_a.rd_busy}, 32'd0);
        ra[0] = 5'd31; ra[1] = 5'd9;
        #1 check("lit_fl_a31_9", {30'd0, bus_a.rd_busy}, 32'd0);

        // Out-of-range register on the 24-entry file
        step(); wr_en = 1'b1; wr_addr = 5'd28; wr_data = 32'h28; alloc_en = 1'b1; alloc_addr = 5'd28;
        for (int i = 0; i < 4; i++) ra[i] = 5'd28;
        #1 check("lit_oor_c_rd", bus_c.rd_data[31:0], 32'd0);
        check("lit_oor_a_rd", bus_a.rd_data[31:0], 32'h28);
        step();
        #1 check("lit_oor_a_busy", {31'd0, bus_a.rd_busy[0]}, 32'd1);
        check("lit_oor_c_busy", {31'd0, bus_c.rd_busy[3]}, 32'd0);
        check("lit_oor_c_rd2", bus_c.rd_data[127:96], 32'd0);

        // Repeated alloc: a single write clears it
        ra[0] = 5'd12;
        step(); alloc_en = 1'b1; alloc_addr = 5'd12;
        step(); alloc_en = 1'b1; alloc_addr = 5'd12;
        step(); wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000000C;
        #1 check("lit_r12_b_busy", {31'd0, bus_b.rd_busy[0]}, 32'd1);
        step();
        #1 check("lit_r12_cleared", {31'd0, bus_b.rd_busy[0]}, 32'd0);

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
